// File: rtl/score_pkg.sv
// score_pkg: shared types and defaults for the score tracker.
// Contents: round state enum, score ceiling and combo step defaults, combo width.
package score_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    localparam int MAX_SCORE_DEF  = 999;
    localparam int COMBO_STEP_DEF = 4;
    localparam int COMBO_W        = 4;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one load cycle then ten shift cycles.
// Ports: clk, resetn (async active-low); start/bin[9:0] request a conversion while idle;
// busy is high while converting; done pulses when the digits are loaded;
// digit_hi/digit_mid/digit_lo hold the last completed result and change together.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_mid,
    output logic [3:0] digit_lo
);
    // sr = {hundreds, tens, units, remaining binary bits}
    logic [21:0] sr, adj;
    logic [3:0]  cnt;

    always_comb begin
        adj = sr;
        for (int i = 0; i < 3; i++)
            adj[10+4*i +: 4] = (sr[10+4*i +: 4] > 4'd4) ? sr[10+4*i +: 4] + 4'd3 : sr[10+4*i +: 4];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            digit_hi  <= '0;
            digit_mid <= '0;
            digit_lo  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                sr  <= {adj[20:0], 1'b0};
                cnt <= cnt + 4'd1;
                // last shift: publish the shifted BCD field directly so all digits land together
                if (cnt == 4'd9) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    {digit_hi, digit_mid, digit_lo} <= adj[20:9];
                end
            end else if (start) begin
                sr   <= {12'd0, bin};
                cnt  <= '0;
                busy <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/score_tracker.sv
// score_tracker: round FSM, combo-multiplied saturating score, high score and BCD display.
// Ports: clk, resetn (async active-low); game_start/game_over/hit/miss pulses, hit_value[3:0];
// score[9:0], high_score[9:0], combo[3:0], playing; digit_hi/mid/lo BCD of score;
// digits_valid high when the digits match the current score.
module score_tracker
    import score_pkg::*;
#(
    parameter int MAX_SCORE  = MAX_SCORE_DEF,
    parameter int COMBO_STEP = COMBO_STEP_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               hit,
    input  logic [3:0]         hit_value,
    input  logic               miss,
    output logic [9:0]         score,
    output logic [9:0]         high_score,
    output logic [COMBO_W-1:0] combo,
    output logic               playing,
    output logic [3:0]         digit_hi,
    output logic [3:0]         digit_mid,
    output logic [3:0]         digit_lo,
    output logic               digits_valid
);
    localparam logic [COMBO_W-1:0] STEP      = COMBO_W'(COMBO_STEP);
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [11:0]        MAX12     = 12'(MAX_SCORE);

    state_t             state, next_state;
    logic [COMBO_W-1:0] lvl;
    logic [2:0]         mult;
    logic [11:0]        sum;
    logic [9:0]         score_next;
    logic [9:0]         pending, shown;
    logic               busy, done, start;

    always_comb begin
        next_state = state;
        if (game_start)
            next_state = PLAY;
        else if (state == PLAY && game_over)
            next_state = OVER;
        lvl        = combo / STEP;
        mult       = (lvl > COMBO_W'(3)) ? 3'd4 : 3'(lvl) + 3'd1;
        // 12-bit sum: worst case 999 + 15*4 cannot wrap before the ceiling clamps it
        sum        = 12'(score) + 12'(hit_value) * 12'(mult);
        score_next = (sum > MAX12) ? MAX12[9:0] : sum[9:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    assign playing = (state == PLAY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score      <= '0;
            combo      <= '0;
            high_score <= '0;
        end else if (game_start) begin
            score <= '0;
            combo <= '0;
        end else if (state == PLAY) begin
            if (game_over) begin
                if (score > high_score)
                    high_score <= score;
            end else if (miss)
                combo <= '0;
            else if (hit) begin
                score <= score_next;
                combo <= (combo == COMBO_MAX) ? combo : combo + 1'b1;
            end
        end
    end

    // pending: value handed to the converter; shown: value whose digits are on the outputs
    assign start        = !busy && (score != pending);
    assign digits_valid = (score == shown);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            shown   <= '0;
        end else begin
            if (start)
                pending <= score;
            if (done)
                shown <= pending;
        end
    end

    bin2bcd_seq u_bcd (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bin       (score),
        .busy      (busy),
        .done      (done),
        .digit_hi  (digit_hi),
        .digit_mid (digit_mid),
        .digit_lo  (digit_lo)
    );
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed stimulus with a scoreboard queue and a decoupled monitor.
module tb_score_tracker;
    typedef struct {
        int sc;
        int cb;
        int hs;
        int pl;
    } exp_t;

    logic       clk, resetn, game_start, game_over, hit, miss, playing, digits_valid;
    logic [3:0] hit_value, combo, digit_hi, digit_mid, digit_lo;
    logic [9:0] score, high_score;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;
    int    limit  = 24;

    score_tracker dut (
        .clk          (clk),
        .resetn       (resetn),
        .game_start   (game_start),
        .game_over    (game_over),
        .hit          (hit),
        .hit_value    (hit_value),
        .miss         (miss),
        .score        (score),
        .high_score   (high_score),
        .combo        (combo),
        .playing      (playing),
        .digit_hi     (digit_hi),
        .digit_mid    (digit_mid),
        .digit_lo     (digit_lo),
        .digits_valid (digits_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endfunction

    // monitor: compares the oldest expectation once the DUT presents settled digits
    initial begin
        exp_t  e;
        string n;
        int    waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0)
                waited = 0;
            else if (digits_valid) begin
                e = q.pop_front();
                n = nq.pop_front();
                chk({n, " score"}, int'(score), e.sc);
                chk({n, " combo"}, int'(combo), e.cb);
                chk({n, " high"}, int'(high_score), e.hs);
                chk({n, " playing"}, int'(playing), e.pl);
                chk({n, " digit_hi"}, int'(digit_hi), e.sc / 100);
                chk({n, " digit_mid"}, int'(digit_mid), (e.sc / 10) % 10);
                chk({n, " digit_lo"}, int'(digit_lo), e.sc % 10);
                waited = 0;
            end else if (++waited > limit) begin
                n = nq.pop_front();
                e = q.pop_front();
                chk({n, " timeout digits_valid"}, int'(digits_valid), 1);
                waited = 0;
            end
        end
    end

    task automatic expect_st(input string n, input int sc, input int cb, input int hs, input int pl);
        q.push_back('{sc, cb, hs, pl});
        nq.push_back(n);
        while (q.size() != 0) @(negedge clk);
    endtask

    task automatic drive(input logic gs, input logic go, input logic h, input logic [3:0] hv, input logic m);
        @(posedge clk);
        #1;
        game_start = gs;
        game_over  = go;
        hit        = h;
        hit_value  = hv;
        miss       = m;
        @(posedge clk);
        #1;
        game_start = 1'b0;
        game_over  = 1'b0;
        hit        = 1'b0;
        hit_value  = 4'd0;
        miss       = 1'b0;
    endtask

    task automatic hit_n(input logic [3:0] v);
        drive(1'b0, 1'b0, 1'b1, v, 1'b0);
    endtask

    task automatic start_n();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic over_n();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; game_start = 1'b0; game_over = 1'b0;
        hit = 1'b0; hit_value = 4'd0; miss = 1'b0;
        #22 resetn = 1'b1;
        expect_st("reset", 0, 0, 0, 0);
        // five hits of 3: 3,6,9,12 then multiplier 2 -> 18
        start_n();
        expect_st("start", 0, 0, 0, 1);
        repeat (5) hit_n(4'd3);
        expect_st("five_hits", 18, 5, 0, 1);
        // simultaneous hit and miss: miss wins
        start_n();
        hit_n(4'd10);
        repeat (5) hit_n(4'd0);
        expect_st("pre_miss", 10, 6, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        expect_st("hit_miss", 10, 0, 0, 1);
        // high score tracking across rounds
        start_n();
        hit_n(4'd15);
        hit_n(4'd15);
        over_n();
        expect_st("over30", 30, 2, 30, 0);
        hit_n(4'd5);
        expect_st("over_hit_ignored", 30, 2, 30, 0);
        start_n();
        repeat (3) hit_n(4'd14);
        over_n();
        expect_st("over42", 42, 3, 42, 0);
        start_n();
        expect_st("cleared", 0, 0, 42, 1);
        hit_n(4'd10);
        hit_n(4'd10);
        over_n();
        expect_st("over20", 20, 2, 42, 0);
        // start and over together: start wins, round restarts
        start_n();
        hit_n(4'd7);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        expect_st("start_over", 0, 0, 42, 1);
        // saturation: 3, combo to 15, 16x60 -> 963, +32 -> 995, +16 -> 999
        hit_n(4'd3);
        repeat (14) hit_n(4'd0);
        repeat (16) hit_n(4'd15);
        hit_n(4'd8);
        expect_st("score995", 995, 15, 42, 1);
        hit_n(4'd4);
        expect_st("saturate", 999, 15, 42, 1);
        hit_n(4'd15);
        expect_st("saturate_hold", 999, 15, 42, 1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        hit_n(4'd0);
        expect_st("zero_hit", 999, 1, 42, 1);
        // two hits three cycles apart while converting
        start_n();
        expect_st("restart", 0, 0, 42, 1);
        hit_n(4'd5);
        chk("valid_after_hit1", int'(digits_valid), 0);
        @(posedge clk);
        #1;
        chk("valid_between_hits", int'(digits_valid), 0);
        hit_n(4'd6);
        chk("valid_after_hit2", int'(digits_valid), 0);
        expect_st("two_hits", 11, 2, 42, 1);
        // asynchronous reset in the middle of a conversion
        hit_n(4'd9);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst score", int'(score), 0);
        chk("rst high", int'(high_score), 0);
        chk("rst combo", int'(combo), 0);
        chk("rst playing", int'(playing), 0);
        chk("rst digit_hi", int'(digit_hi), 0);
        chk("rst digit_mid", int'(digit_mid), 0);
        chk("rst digit_lo", int'(digit_lo), 0);
        chk("rst valid", int'(digits_valid), 1);
        #10 resetn = 1'b1;
        expect_st("post_reset", 0, 0, 0, 0);
        start_n();
        hit_n(4'd5);
        expect_st("after_reset", 5, 1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
